store_packer: RTL and testbench
===============================

STORE_PACKER -- requirements
Module: store_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning queue entries (power of two, >=2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1, store request present.
REQ-005 SHALL have port in_ready, output, 1, packer can accept a request.
REQ-006 SHALL have port addr, input, 32, byte address of the store.
REQ-007 SHALL have port wdata, input, 32, register data; the store uses its low byte, half or full word.
REQ-008 SHALL have port SOp, input, 2, store size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-009 SHALL have port mem_valid, output, 1, head entry presented to memory.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts the head entry.
REQ-011 SHALL have port mem_addr, output, 32, word address {addr[31:2],2'b00}.
REQ-012 SHALL have port mem_wdata, output, 32, lane-positioned store data.
REQ-013 SHALL have port mem_be, output, 4, byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-014 SHALL have port misalign, output, 1, one-cycle pulse for a rejected misaligned store.
REQ-015 SHALL have port exc_addr, output, 32, byte address of the last misaligned store.

Function
REQ-016 SHALL accept a request on a cycle with in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH) && !reset, with no same-cycle bypass when full.
REQ-018 SHALL pack a word store as data = wdata and be = 4'b1111.
REQ-019 SHALL pack a half store as data = {2{wdata[15:0]}} and be = addr[1] ? 4'b1100 : 4'b0011.
REQ-020 SHALL pack a byte store as data = {4{wdata[7:0]}} and be = 4'b0001 << addr[1:0].
REQ-021 SHALL accept an SOp=11 request, discard it, create no entry and raise no flag.
REQ-022 SHALL present an entry on mem_valid no earlier than the cycle after its acceptance, giving a minimum latency of 1.
REQ-023 SHALL pop the head entry on mem_valid && mem_ready and keep mem_addr/mem_wdata/mem_be stable while mem_valid && !mem_ready.
REQ-024 SHALL hold count unchanged on a simultaneous push and pop, including when count==DEPTH-1, and SHALL never push when full.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL drain entries in acceptance order.
REQ-027 SHALL drive mem_valid = (count != 0).
REQ-028 SHALL define occupancy states EMPTY (count 0), PART (0<count<DEPTH) and FULL (count DEPTH), which SHALL change only by push or pop.

Reset
REQ-029 SHALL, on a clock edge with reset high, clear pointers and count and drive mem_valid=0, misalign=0, exc_addr=0 and mem_be=0.
REQ-030 SHALL discard queued entries on reset mid-operation without emitting them, and SHALL ignore in_valid during reset.
REQ-031 SHALL present in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-032 SHALL provide the macro STORE_PACKER_MISALIGN_TRAP_EN.
REQ-033 SHALL, with STORE_PACKER_MISALIGN_TRAP_EN defined, accept and drop any half store with addr[0]=1 or word store with addr[1:0]!=0, pulse misalign for the cycle after acceptance, load exc_addr with addr, and create no entry.
REQ-034 SHALL, without STORE_PACKER_MISALIGN_TRAP_EN, ignore addr[0] for half stores and addr[1:0] for word stores, tie misalign to 0 and tie exc_addr to 0.

Verification
REQ-035 SHALL cover a byte store with addr=0x1003, wdata=0x123456AB, SOp=10 -> next cycle mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB.
REQ-036 SHALL cover a half store with addr=0x2002, wdata=0xFFFFBEEF, SOp=01 -> mem_be=1100, mem_wdata=0xBEEFBEEF.
REQ-037 SHALL cover three word stores with mem_ready=0 and DEPTH=2 -> in_ready=0 after two accepts; raising mem_ready drains them in order, and the third is accepted the cycle after the first pop.
REQ-038 SHALL cover a simultaneous push and pop at count=1 -> count stays 1 and the order is preserved.
REQ-039 SHALL cover, with the trap enabled, a word store at addr=0x3001 -> misalign=1 for one cycle, exc_addr=0x3001, no mem_valid; with the trap disabled, the same store gives mem_addr=0x3000, mem_be=1111.
REQ-040 SHALL cover reset asserted with 2 entries queued -> next cycle mem_valid=0 and count=0, and in_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/store_packer.sv
`default_nettype none
// store_packer: queues byte/half/word stores as lane-positioned word writes with byte enables.
// Optional macro STORE_PACKER_MISALIGN_TRAP_EN drops misaligned half/word stores and reports them.
module store_packer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  SOp,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  output logic [31:0] exc_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;

  logic [29:0] addr_mem_q [DEPTH];
  logic [31:0] data_mem_q [DEPTH];
  logic [3:0]  be_mem_q   [DEPTH];

  logic [31:0] pack_data;
  logic [3:0]  pack_be;
  logic        sop_valid;
  logic        misaligned;
  logic        accept, push, pop;

  always_comb begin
    pack_data = wdata;
    pack_be   = 4'b0000;
    sop_valid = 1'b1;
    case (SOp)
      2'b00: pack_be = 4'b1111;
      2'b01: begin
        pack_data = {2{wdata[15:0]}};
        pack_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        pack_data = {4{wdata[7:0]}};
        pack_be   = 4'b0001 << addr[1:0];
      end
      default: sop_valid = 1'b0;
    endcase
  end

`ifdef STORE_PACKER_MISALIGN_TRAP_EN
  assign misaligned = ((SOp == 2'b00) && (addr[1:0] != 2'b00)) ||
                      ((SOp == 2'b01) && addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  // Reserved-size and trapped stores are still handshaken, but never enqueued.
  assign accept = in_valid && in_ready;
  assign push   = accept && sop_valid && !misaligned;
  assign pop    = mem_valid && mem_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d = ST_PART;
    if (count_d == '0)          state_d = ST_EMPTY;
    else if (count_d == C_DEPTH) state_d = ST_FULL;
  end

  always_comb begin
    in_ready  = (state_q != ST_FULL) && !reset;
    mem_valid = (state_q != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= addr[31:2];
      data_mem_q[wr_ptr_q] <= pack_data;
      be_mem_q[wr_ptr_q]   <= pack_be;
    end
  end

  assign mem_addr  = {addr_mem_q[rd_ptr_q], 2'b00};
  assign mem_wdata = data_mem_q[rd_ptr_q];
  assign mem_be    = mem_valid ? be_mem_q[rd_ptr_q] : 4'b0000;

`ifdef STORE_PACKER_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic [31:0] exc_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      misalign_q <= accept && misaligned;
      if (accept && misaligned) exc_addr_q <= addr;
    end
  end

  assign misalign = misalign_q;
  assign exc_addr = exc_addr_q;
`else
  assign misalign = 1'b0;
  assign exc_addr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_packer.sv
`default_nettype none
// tb_store_packer: table-driven single-store vectors plus hand-written fill/drain and reset sequences.
module tb_store_packer;

`ifdef STORE_PACKER_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  SOp;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;

  store_packer #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr      (addr),
    .wdata     (wdata),
    .SOp       (SOp),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .misalign  (misalign),
    .exc_addr  (exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sop;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic        exp_mis;
    logic [31:0] exp_exc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    addr     = a;
    wdata    = d;
    SOp      = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1003, 32'h1234_56AB, 2'b10, 1'b1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_2002, 32'hFFFF_BEEF, 2'b01, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_2000, 32'h0000_CAFE, 2'b01, 1'b1, 32'h0000_2000, 32'hCAFE_CAFE, 4'b0011, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_1000, 32'h0000_0055, 2'b10, 1'b1, 32'h0000_1000, 32'h5555_5555, 4'b0001, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_1001, 32'h0000_00A1, 2'b10, 1'b1, 32'h0000_1000, 32'hA1A1_A1A1, 4'b0010, 1'b0, 32'h0};
    vecs[5] = '{32'h0000_4000, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_5000, 32'h1111_1111, 2'b11, 1'b0, 32'h0,         32'h0,         4'b0000, 1'b0, 32'h0};
    vecs[7] = TRAP ?
      '{32'h0000_3001, 32'hCAFE_BABE, 2'b00, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 32'h0000_3001} :
      '{32'h0000_3001, 32'hCAFE_BABE, 2'b00, 1'b1, 32'h0000_3000, 32'hCAFE_BABE, 4'b1111, 1'b0, 32'h0};
    vecs[8] = TRAP ?
      '{32'h0000_2003, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 32'h0000_2003} :
      '{32'h0000_2003, 32'h0000_1234, 2'b01, 1'b1, 32'h0000_2000, 32'h1234_1234, 4'b1100, 1'b0, 32'h0};
    vecs[9] = '{32'h0000_1002, 32'h0000_007E, 2'b10, 1'b1, 32'h0000_1000, 32'h7E7E_7E7E, 4'b0100, 1'b0,
                TRAP ? 32'h0000_2003 : 32'h0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    addr      = '0;
    wdata     = '0;
    SOp       = 2'b00;
    mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("reset_in_ready",  {31'b0, in_ready},  32'd0);
    chk("reset_mem_be",    {28'b0, mem_be},    32'd0);
    chk("reset_misalign",  {31'b0, misalign},  32'd0);
    chk("reset_exc_addr",  exc_addr,           32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Single-store vectors: accept, inspect the presented entry, then pop it.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      addr      = vecs[i].addr;
      wdata     = vecs[i].wdata;
      SOp       = vecs[i].sop;
      mem_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].exp_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_data);
      end
      chk($sformatf("v%0d_mem_be", i),    {28'b0, mem_be},   {28'b0, vecs[i].exp_be});
      chk($sformatf("v%0d_misalign", i),  {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      chk($sformatf("v%0d_exc_addr", i),  exc_addr,          vecs[i].exp_exc);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk($sformatf("v%0d_drained", i),      {31'b0, mem_valid}, 32'd0);
      chk($sformatf("v%0d_misalign_off", i), {31'b0, misalign},  32'd0);
    end

    // Fill to DEPTH with memory stalled, then drain in order with a push/pop at count 1.
    @(negedge clk);
    push_word(32'h0000_A000, 32'hAAAA_0001);
    @(negedge clk);
    chk("fill_a_valid", {31'b0, mem_valid}, 32'd1);
    chk("fill_a_addr",  mem_addr,           32'h0000_A000);
    chk("fill_a_ready", {31'b0, in_ready},  32'd1);
    push_word(32'h0000_B000, 32'hBBBB_0002);
    @(negedge clk);
    chk("full_in_ready",  {31'b0, in_ready}, 32'd0);
    chk("full_head_addr", mem_addr,          32'h0000_A000);
    push_word(32'h0000_C000, 32'hCCCC_0003);
    @(negedge clk);
    chk("stall_in_ready",   {31'b0, in_ready}, 32'd0);
    chk("stall_head_addr",  mem_addr,          32'h0000_A000);
    chk("stall_head_wdata", mem_wdata,         32'hAAAA_0001);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("pop_a_head_addr", mem_addr,          32'h0000_B000);
    chk("pop_a_in_ready",  {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pushpop_valid",    {31'b0, mem_valid}, 32'd1);
    chk("pushpop_in_ready", {31'b0, in_ready},  32'd1);
    chk("pushpop_addr",     mem_addr,           32'h0000_C000);
    chk("pushpop_wdata",    mem_wdata,          32'hCCCC_0003);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("drain_done_valid", {31'b0, mem_valid}, 32'd0);

    // Reset with two entries queued: nothing may be emitted afterwards.
    @(negedge clk);
    push_word(32'h0000_6000, 32'h6666_0000);
    @(negedge clk);
    push_word(32'h0000_6004, 32'h6666_0004);
    @(negedge clk);
    chk("prereset_full", {31'b0, in_ready}, 32'd0);
    push_word(32'h0000_6008, 32'h6666_0008);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_valid",    {31'b0, mem_valid}, 32'd0);
    chk("midreset_be",       {28'b0, mem_be},    32'd0);
    chk("midreset_in_ready", {31'b0, in_ready},  32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("afterreset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("afterreset_valid",  {31'b0, mem_valid}, 32'd0);
    chk("afterreset_ready2", {31'b0, in_ready},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
